// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle control FSM and its datapath/memory side.
// master = control FSM, slave = datapath and memories.
interface mc_control_fsm_if;
   logic [31:0] instr_rdata;
   logic        imem_ack;
   logic        dmem_ack;
   logic        branch_taken;
   logic        imem_req;
   logic        dmem_req;
   logic        pc_en;
   logic        pc_sel;
   logic        register_write_en;
   logic        mem_write_en;
   logic        imm_en;
   logic [3:0]  alu_control_en;
   logic [1:0]  rd_mux_en;
   logic [2:0]  S_type_data;
   logic [2:0]  L_type_data;
   logic [2:0]  B_type_data;
   logic        illegal_instr;
   logic        mem_fault;
   logic [2:0]  state_o;

   modport master (
      input  instr_rdata, imem_ack, dmem_ack, branch_taken,
      output imem_req, dmem_req, pc_en, pc_sel, register_write_en, mem_write_en,
             imm_en, alu_control_en, rd_mux_en, S_type_data, L_type_data,
             B_type_data, illegal_instr, mem_fault, state_o
   );

   modport slave (
      output instr_rdata, imem_ack, dmem_ack, branch_taken,
      input  imem_req, dmem_req, pc_en, pc_sel, register_write_en, mem_write_en,
             imm_en, alu_control_en, rd_mux_en, S_type_data, L_type_data,
             B_type_data, illegal_instr, mem_fault, state_o
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXECUTE/MEM/WB with memory-ack
// timeout into a sticky HALT. Outputs are decoded from state and the latched IR.
module mc_control_fsm #(
   parameter int MEM_TIMEOUT = 16
) (
   input logic            clk,
   input logic            reset,
   mc_control_fsm_if.master bus
);
   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM     = 3'd3,
      WB      = 3'd4,
      HALT    = 3'd5
   } state_t;

   localparam int            CW        = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);
   localparam logic [31:0]   NOP       = 32'h0000_0013;

   state_t        state, next_state;
   logic [31:0]   ir;
   logic [CW-1:0] wait_cnt;
   logic          fault;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       is_r, is_i, is_s, is_l, is_b, is_lui, is_auipc;
   logic       waiting, timeout;
   logic       unused_ir;

   assign opcode   = ir[6:0];
   assign funct3   = ir[14:12];
   assign funct7_5 = ir[30];
   assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

   assign is_r     = (opcode == 7'b0110011);
   assign is_i     = (opcode == 7'b0010011);
   assign is_s     = (opcode == 7'b0100011);
   assign is_l     = (opcode == 7'b0000011);
   assign is_b     = (opcode == 7'b1100011);
   assign is_lui   = (opcode == 7'b0110111);
   assign is_auipc = (opcode == 7'b0010111);

   // Only the request state's own ack matters; stray acks elsewhere are ignored.
   assign waiting = ((state == FETCH) && !bus.imem_ack) ||
                    ((state == MEM)   && !bus.dmem_ack);
   assign timeout = waiting && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= FETCH;
         ir       <= NOP;
         wait_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         state <= next_state;
         if (state == FETCH && bus.imem_ack)
            ir <= bus.instr_rdata;
         if (next_state != state)
            wait_cnt <= '0;
         else if (waiting)
            wait_cnt <= wait_cnt + 1'b1;
         if (next_state == HALT && state != HALT)
            fault <= 1'b1;
      end
   end

   always_comb begin
      next_state            = state;
      bus.imem_req          = 1'b0;
      bus.dmem_req          = 1'b0;
      bus.pc_en             = 1'b0;
      bus.pc_sel            = 1'b0;
      bus.register_write_en = 1'b0;
      bus.mem_write_en      = 1'b0;
      bus.imm_en            = 1'b0;
      bus.alu_control_en    = 4'b0000;
      bus.rd_mux_en         = 2'b00;
      bus.S_type_data       = 3'b000;
      bus.L_type_data       = 3'b000;
      bus.illegal_instr     = 1'b0;
      case (state)
         FETCH: begin
            // Reset parks the FSM in FETCH; keep the request quiet until release.
            bus.imem_req = !reset;
            if (bus.imem_ack)
               next_state = DECODE;
            else if (timeout)
               next_state = HALT;
         end
         DECODE: begin
            if (is_r || is_i || is_s || is_l || is_b)
               next_state = EXECUTE;
            else if (is_lui || is_auipc)
               next_state = WB;
            else begin
               bus.illegal_instr = 1'b1;
               bus.pc_en         = 1'b1;
               next_state        = FETCH;
            end
         end
         EXECUTE: begin
            if (is_r || (is_i && funct3 == 3'b101))
               bus.alu_control_en = {funct7_5, funct3};
            else if (is_i)
               bus.alu_control_en = {1'b0, funct3};
            bus.imm_en = is_i || is_s || is_l;
            if (is_s || is_l)
               next_state = MEM;
            else if (is_b) begin
               bus.pc_en  = 1'b1;
               bus.pc_sel = bus.branch_taken;
               next_state = FETCH;
            end else
               next_state = WB;
         end
         MEM: begin
            bus.dmem_req     = 1'b1;
            bus.mem_write_en = is_s;
            bus.S_type_data  = is_s ? funct3 : 3'b000;
            bus.L_type_data  = is_l ? funct3 : 3'b000;
            if (bus.dmem_ack) begin
               if (is_s) begin
                  bus.pc_en  = 1'b1;
                  next_state = FETCH;
               end else
                  next_state = WB;
            end else if (timeout)
               next_state = HALT;
         end
         WB: begin
            bus.register_write_en = 1'b1;
            bus.pc_en             = 1'b1;
            if (is_l)
               bus.rd_mux_en = 2'b01;
            else if (is_lui)
               bus.rd_mux_en = 2'b10;
            else if (is_auipc)
               bus.rd_mux_en = 2'b11;
            next_state = FETCH;
         end
         HALT: next_state = HALT;
         default: next_state = FETCH;
      endcase
   end

   assign bus.B_type_data = is_b ? funct3 : 3'b000;
   assign bus.mem_fault   = fault;
   assign bus.state_o     = state;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized lockstep bench: a per-instruction-class model predicts every
// cycle's state and control outputs from the decoded instruction and ack timing.
module tb_mc_control_fsm;
   localparam int          TMO = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum {K_R, K_I, K_S, K_L, K_B, K_LUI, K_AUI, K_BAD} kind_t;

   typedef struct packed {
      logic [2:0] st;
      logic       ireq, dreq, pce, pcs, rwe, mwe, imm;
      logic [3:0] alu;
      logic [1:0] rdm;
      logic [2:0] s, l, b;
      logic       ill, flt;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   mc_control_fsm_if mc_if();

   mc_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mc_if.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [31:0] m_ir = NOP;
   logic        m_fault = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic kind_t kind_of(input logic [31:0] ins);
      case (ins[6:0])
         7'h33:   return K_R;
         7'h13:   return K_I;
         7'h23:   return K_S;
         7'h03:   return K_L;
         7'h63:   return K_B;
         7'h37:   return K_LUI;
         7'h17:   return K_AUI;
         default: return K_BAD;
      endcase
   endfunction

   function automatic exp_t base();
      exp_t e = '0;
      e.b   = (kind_of(m_ir) == K_B) ? m_ir[14:12] : 3'b000;
      e.flt = m_fault;
      return e;
   endfunction

   function automatic exp_t obs();
      exp_t o;
      o.st  = mc_if.state_o;          o.ireq = mc_if.imem_req;
      o.dreq = mc_if.dmem_req;        o.pce  = mc_if.pc_en;
      o.pcs = mc_if.pc_sel;           o.rwe  = mc_if.register_write_en;
      o.mwe = mc_if.mem_write_en;     o.imm  = mc_if.imm_en;
      o.alu = mc_if.alu_control_en;   o.rdm  = mc_if.rd_mux_en;
      o.s   = mc_if.S_type_data;      o.l    = mc_if.L_type_data;
      o.b   = mc_if.B_type_data;      o.ill  = mc_if.illegal_instr;
      o.flt = mc_if.mem_fault;
      return o;
   endfunction

   // Inputs are driven just after a negedge; outputs sampled 1 time unit later.
   task automatic step(input string tag, input exp_t e);
      #1;
      chk(tag, 32'(obs()), 32'(e));
      @(negedge clk);
      cyc++;
   endtask

   task automatic noise();
      mc_if.imem_ack     = 1'($urandom);
      mc_if.dmem_ack     = 1'($urandom);
      mc_if.branch_taken = 1'($urandom);
      mc_if.instr_rdata  = $urandom;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_ir = NOP;
      m_fault = 1'b0;
      #1;
      chk("rst_outs", 32'(obs()), 32'(base()));
      chk("rst_ir", dut.ir, NOP);
      @(negedge clk);
      cyc++;
      reset = 1'b0;
   endtask

   // abort_mem >= 0 asserts reset asynchronously in that MEM cycle.
   task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                            input logic taken, input int abort_mem);
      kind_t k = kind_of(ins);
      logic [2:0] f3 = ins[14:12];
      int   nmem;
      logic ack;
      exp_t e;
      for (int c = 0; c <= iw; c++) begin
         noise();
         mc_if.imem_ack    = (c == iw);
         mc_if.instr_rdata = (c == iw) ? ins : $urandom;
         e = base(); e.st = 3'd0; e.ireq = 1'b1;
         step("fetch", e);
      end
      m_ir = ins;
      noise();
      e = base(); e.st = 3'd1;
      if (k == K_BAD) begin e.ill = 1'b1; e.pce = 1'b1; end
      step("decode", e);
      if (k == K_BAD) return;
      if (k inside {K_R, K_I, K_S, K_L, K_B}) begin
         noise();
         mc_if.branch_taken = taken;
         e = base(); e.st = 3'd2;
         if (k == K_R || (k == K_I && f3 == 3'd5)) e.alu = {ins[30], f3};
         else if (k == K_I)                       e.alu = {1'b0, f3};
         e.imm = (k == K_I || k == K_S || k == K_L);
         if (k == K_B) begin e.pce = 1'b1; e.pcs = taken; end
         step("execute", e);
         if (k == K_B) return;
      end
      if (k == K_S || k == K_L) begin
         nmem = (dw >= TMO) ? TMO : dw + 1;
         for (int c = 0; c < nmem; c++) begin
            noise();
            ack = (c == dw);
            mc_if.dmem_ack = ack;
            e = base(); e.st = 3'd3; e.dreq = 1'b1;
            e.mwe = (k == K_S);
            e.s = (k == K_S) ? f3 : 3'b000;
            e.l = (k == K_L) ? f3 : 3'b000;
            e.pce = (k == K_S) && ack;
            if (c == abort_mem) begin
               #1;
               chk("pre_abort", 32'(obs()), 32'(e));
               #1;
               reset = 1'b1;
               m_ir = NOP;
               m_fault = 1'b0;
               #1;
               chk("abort_outs", 32'(obs()), 32'(base()));
               chk("abort_ir", dut.ir, NOP);
               @(negedge clk);
               cyc++;
               #1;
               chk("abort_hold", 32'(obs()), 32'(base()));
               reset = 1'b0;
               return;
            end
            step("mem", e);
         end
         if (dw >= TMO) begin
            m_fault = 1'b1;
            for (int c = 0; c < 4; c++) begin
               noise();
               e = base(); e.st = 3'd5;
               step("halt", e);
            end
            return;
         end
         if (k == K_S) return;
      end
      noise();
      e = base(); e.st = 3'd4; e.rwe = 1'b1; e.pce = 1'b1;
      e.rdm = (k == K_L) ? 2'b01 : (k == K_LUI) ? 2'b10 : (k == K_AUI) ? 2'b11 : 2'b00;
      step("wb", e);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [7] = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h37, 7'h17};
      logic [31:0] r = $urandom;
      int          idx = $urandom_range(0, 7);
      logic [6:0]  op;
      if (idx < 7) op = ops[idx];
      else begin
         op = 7'($urandom);
         while (kind_of({25'd0, op}) != K_BAD) op = 7'($urandom);
      end
      return {r[31:7], op};
   endfunction

   initial begin
      int t0;
      mc_if.instr_rdata = '0; mc_if.imem_ack = 1'b0;
      mc_if.dmem_ack = 1'b0;  mc_if.branch_taken = 1'b0;
      @(negedge clk);
      noise();
      #1;
      chk("reset_state", 32'(obs()), 32'(base()));
      chk("reset_ir", dut.ir, NOP);
      @(negedge clk);
      reset = 1'b0;

      run_instr(32'h002081B3, 0, 0, 1'b0, -1);          // ADD x3,x1,x2
      t0 = cyc;
      run_instr(32'h0000A103, 0, 3, 1'b0, -1);          // LW, ack after 3 waits
      chk("lw_cycles", 32'(cyc - t0), 32'd8);
      t0 = cyc;
      run_instr(32'h00208463, 0, 0, 1'b1, -1);          // BEQ taken
      chk("beq_cycles", 32'(cyc - t0), 32'd3);
      run_instr(32'h00208463, 1, 0, 1'b0, -1);          // BEQ not taken
      run_instr(32'h0000007F, 0, 0, 1'b0, -1);          // illegal opcode
      t0 = cyc;
      run_instr(32'h123450B7, 0, 0, 1'b0, -1);          // LUI
      chk("lui_cycles", 32'(cyc - t0), 32'd3);

      for (int i = 0; i < 150; i++)
         run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), -1);

      run_instr(32'h0020A023, 0, TMO, 1'b0, -1);        // SW, dmem never acks
      do_reset();
      run_instr(32'h0020A023, 0, 5, 1'b0, 2);           // SW aborted by reset in MEM
      for (int i = 0; i < 40; i++)
         run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
